// File: rtl/iiitb_apb_bridge_if.sv
// iiitb_apb_bridge_if
// Groups the request/response handshake and the APB fabric signals of the
// iiitb_apb_bridge into one bundle.
//   master modport : the bridge side (drives req_ready, rsp_*, PSEL..PWDATA)
//   slave modport  : the environment side (drives req_*, PRDATA, PREADY, PSLVERR)
// Parameters must match those of the bridge instance the bundle is bound to.
interface iiitb_apb_bridge_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 2
);
  logic                             req_valid;
  logic                             req_ready;
  logic                             req_write;
  logic [ADDR_WIDTH-1:0]            req_addr;
  logic [DATA_WIDTH-1:0]            req_wdata;
  logic                             rsp_valid;
  logic [DATA_WIDTH-1:0]            rsp_rdata;
  logic                             rsp_err;
  logic [NUM_SLAVES-1:0]            PSEL;
  logic                             PENABLE;
  logic                             PWRITE;
  logic [ADDR_WIDTH-1:0]            PADDR;
  logic [DATA_WIDTH-1:0]            PWDATA;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]            PREADY;
  logic [NUM_SLAVES-1:0]            PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/iiitb_apb_bridge.sv
// iiitb_apb_bridge
// Parametrised APB master bridge. Takes single read/write requests on a
// valid/ready port, decodes the top SEL_BITS address bits to a PSEL line,
// runs the APB SETUP/ACCESS sequence (PREADY wait states, PSLVERR) and
// returns a one-cycle response pulse with read data and an error flag.
//
// Ports:
//   PCLK   - clock, rising edge
//   PRESET - synchronous active-high reset; aborts any transfer in flight
//   bus    - iiitb_apb_bridge_if.master: req_*/rsp_* handshake and APB signals
//
// Optional feature macro: APB_TIMEOUT_EN
//   defined   : ACCESS aborts with rsp_err after TIMEOUT_CYCLES PREADY-low cycles
//   undefined : ACCESS waits for PREADY indefinitely
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request; decode errors are answered from here
// SETUP  | PSEL asserted, PENABLE low (single cycle)
// ACCESS | PSEL and PENABLE high, waiting on PREADY of the selected slave
module iiitb_apb_bridge #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_SLAVES     = 2,
  parameter int SEL_BITS       = 1,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               PCLK,
  input  logic               PRESET,
  iiitb_apb_bridge_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [SEL_BITS-1:0]   r_idx;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic [SEL_BITS-1:0]   w_req_idx;
  logic                  w_idx_ok;
  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_sel_ready;
  logic                  w_sel_err;
  logic [DATA_WIDTH-1:0] w_sel_rdata;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_rsp_fire;
  logic                  w_rsp_err;
  logic [DATA_WIDTH-1:0] w_rsp_rdata;
  logic [NUM_SLAVES-1:0] w_psel;

  assign w_req_idx   = bus.req_addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign w_idx_ok    = (int'(w_req_idx) < NUM_SLAVES);
  // Ready is suppressed while PRESET is high so nothing is accepted in reset.
  assign w_req_ready = (r_state == S_IDLE) && !PRESET;
  assign w_accept    = bus.req_valid && w_req_ready;

  // Only the slave captured at acceptance is looked at; the rest are ignored.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(r_idx) == i) begin
        w_sel_ready = bus.PREADY[i];
        w_sel_err   = bus.PSLVERR[i];
        w_sel_rdata = bus.PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  // Held at zero outside ACCESS, so it is clear on the first ACCESS cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET || (r_state != S_ACCESS))
      r_wait_cnt <= '0;
    else if (!w_sel_ready)
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
  end

  // Fires on the PREADY-low cycle that brings the count to the limit;
  // PREADY high on that same cycle is a normal completion instead.
  assign w_timeout = (r_state == S_ACCESS) && !w_sel_ready &&
                     (int'(r_wait_cnt) == TIMEOUT_CYCLES - 1);
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && w_idx_ok) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_sel_ready || w_timeout) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_psel = '0;
    if (r_state != S_IDLE) w_psel = NUM_SLAVES'(1) << r_idx;
    w_done      = (r_state == S_ACCESS) && w_sel_ready;
    w_rsp_fire  = (w_accept && !w_idx_ok) || w_done || w_timeout;
    w_rsp_err   = (w_accept && !w_idx_ok) || w_timeout || (w_done && w_sel_err);
    w_rsp_rdata = (w_done && !r_pwrite && !w_sel_err) ? w_sel_rdata : '0;
  end

  // Transfer attributes are captured on every acceptance (decode errors
  // included) and then held until the next one.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_idx       <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_rsp_fire;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
      if (w_accept) begin
        r_idx    <= w_req_idx;
        r_paddr  <= bus.req_addr;
        r_pwrite <= bus.req_write;
        r_pwdata <= bus.req_wdata;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.PSEL      = w_psel;
  assign bus.PENABLE   = (r_state == S_ACCESS);
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;

endmodule
